// File: rtl/pwm_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_cmd_sequencer
//
// Walks a synchronous command ROM and hands each 16-bit PWM word to the PWM
// core over a valid/ready handshake. After the core accepts a word, that word
// is held for HOLD_TICKS pulses of the slow-rate tick enable before the next
// address is fetched. Two ROM words are reserved as markers: HALT_WORD ends
// the program and LOOP_WORD restarts it from address 0. start/stop give
// run control, and stop/halt/reset all leave SAFE_WORD on cmd_data.
// Everything runs on clk; the slow rate comes only from the tick enable.
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous, active-high reset
//   tick       in   1       1-cycle slow-rate enable pulse
//   start      in   1       pulse: begin the program at address 0
//   stop       in   1       pulse: abort the program, drive SAFE_WORD
//   mem_en     out  1       ROM read enable
//   mem_addr   out  ADDR_W  ROM address
//   mem_data   in   DATA_W  ROM read data, valid the cycle after mem_en
//   cmd_valid  out  1       cmd_data offered to the PWM core
//   cmd_ready  in   1       PWM core accepts; transfer = cmd_valid & cmd_ready
//   cmd_data   out  DATA_W  command word to the PWM core
//   busy       out  1       high in every state except IDLE and DONE
//   done       out  1       1-cycle pulse when HALT_WORD is reached
// -----------------------------------------------------------------------------
module pwm_cmd_sequencer #(
    parameter int                 ADDR_W     = 8,
    parameter int                 DATA_W     = 16,
    parameter int                 HOLD_TICKS = 1,      // must be >= 1
    parameter logic [DATA_W-1:0]  HALT_WORD  = 16'hFFFF,
    parameter logic [DATA_W-1:0]  LOOP_WORD  = 16'hFFFE,
    parameter logic [DATA_W-1:0]  SAFE_WORD  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done
);

    // hold_cnt counts 0 .. HOLD_TICKS-1; the last tick ends the hold.
    localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MEM,
        ISSUE,
        HOLD,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; a blocking = would let later statements see
    // the new value and silently reorder the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= SAFE_WORD;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (stop) begin
            // stop overrides everything, including a start in the same cycle
            // and a handshake still in flight.
            state     <= IDLE;
            hold_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= SAFE_WORD;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // mem_en and done are single-cycle strobes unless re-armed below.
            mem_en <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FETCH;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                    end
                end

                // mem_en is high during this cycle; the ROM answers next cycle.
                FETCH: state <= MEM;

                MEM: begin
                    if (mem_data == HALT_WORD) begin
                        state    <= DONE;
                        cmd_data <= SAFE_WORD;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (mem_data == LOOP_WORD) begin
                        state    <= FETCH;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                    end else begin
                        state     <= ISSUE;
                        cmd_data  <= mem_data;
                        cmd_valid <= 1'b1;
                    end
                end

                // Ticks are ignored here, including one coinciding with the
                // transfer: the hold only starts counting in HOLD.
                ISSUE: begin
                    if (cmd_ready) begin
                        state     <= HOLD;
                        cmd_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end

                HOLD: begin
                    if (tick) begin
                        if (hold_cnt == LAST_TICK) begin
                            state    <= FETCH;
                            mem_en   <= 1'b1;
                            // Natural wrap at 2**ADDR_W-1 keeps the program running.
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                    cmd_data  <= SAFE_WORD;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_cmd_sequencer
//
// Bench for pwm_cmd_sequencer with ADDR_W=2 and HOLD_TICKS=2. A 4-word ROM
// model answers mem_en one cycle later. A background driver produces random
// tick pulses and cmd_ready patterns; a negedge monitor records fetched
// addresses, accepted words and the tick count seen during each hold. Each
// test compares those records against a program walk computed from the ROM
// contents and the marker rules.
// -----------------------------------------------------------------------------
module tb_pwm_cmd_sequencer;

    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 16;
    localparam int HOLD_TICKS = 2;
    localparam int ROM_WORDS  = 4;

    localparam logic [DATA_W-1:0] HALT = 16'hFFFF;
    localparam logic [DATA_W-1:0] LOOP = 16'hFFFE;
    localparam logic [DATA_W-1:0] SAFE = 16'h0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              start;
    logic              stop;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_cmd_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .HOLD_TICKS(HOLD_TICKS),
        .HALT_WORD (HALT),
        .LOOP_WORD (LOOP),
        .SAFE_WORD (SAFE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .busy     (busy),
        .done     (done)
    );

    // Synchronous ROM model.
    logic [DATA_W-1:0] rom [ROM_WORDS];
    initial mem_data = '0;
    always @(posedge clk) if (mem_en) mem_data <= rom[mem_addr];

    // Background driver: tick pulses (never two in a row) and cmd_ready.
    // ready_mode: 0 = hold low, 1 = hold high, 2 = random.
    int tick_en    = 0;
    int ready_mode = 0;
    initial begin
        tick      = 1'b0;
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tick_en != 0) && !tick && ($urandom_range(0, 2) == 0);
            case (ready_mode)
                0:       cmd_ready = 1'b0;
                1:       cmd_ready = 1'b1;
                default: cmd_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: records observable events once per cycle.
    int                fetch_q [$];
    logic [DATA_W-1:0] xfer_q  [$];
    int                hold_q  [$];
    int                hold_bad;
    int                done_cnt;
    bit                in_hold;
    int                tick_cnt;
    logic [DATA_W-1:0] last_word;

    always @(negedge clk) begin
        if (rst || stop) begin
            in_hold  = 1'b0;
            tick_cnt = 0;
        end else begin
            if (done) done_cnt++;
            if (mem_en) begin
                fetch_q.push_back(int'(mem_addr));
                if (in_hold) begin
                    hold_q.push_back(tick_cnt);
                    in_hold = 1'b0;
                end
            end else if (in_hold) begin
                if (tick) tick_cnt++;
                if (cmd_data !== last_word) hold_bad++;
            end
            if (cmd_valid && cmd_ready) begin
                xfer_q.push_back(cmd_data);
                last_word = cmd_data;
                in_hold   = 1'b1;
                tick_cnt  = 0;
            end
        end
    end

    // Reference: walk the program from address 0 using the marker rules.
    int                exp_fetch [$];
    logic [DATA_W-1:0] exp_issue [$];

    function automatic void build_model(input int n_fetch);
        int                addr;
        logic [DATA_W-1:0] w;
        exp_fetch.delete();
        exp_issue.delete();
        addr = 0;
        for (int i = 0; i < n_fetch; i++) begin
            exp_fetch.push_back(addr);
            w = rom[addr];
            if (w == HALT) break;
            if (w == LOOP) begin
                addr = 0;
            end else begin
                exp_issue.push_back(w);
                addr = (addr + 1) % ROM_WORDS;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        fetch_q.delete();
        xfer_q.delete();
        hold_q.delete();
        hold_bad = 0;
        done_cnt = 0;
        in_hold  = 1'b0;
        tick_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Returns at the negedge of the first cycle where the condition holds.
    // which: 0 = cmd_valid, 1 = transfer, 2 = done, 3 = mem_en
    task automatic wait_for(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && cmd_valid) ||
                (which == 1 && cmd_valid && cmd_ready) ||
                (which == 2 && done) ||
                (which == 3 && mem_en)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        tick_en = 0; ready_mode = 0;
        step(); step();
        @(negedge clk);
        checks++; if (mem_en !== 1'b0)    begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        checks++; if (cmd_data !== SAFE)  begin errors++; $display("FAIL reset_cmd_data: got %h want %h", cmd_data, SAFE); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        step();
        rst = 1'b0;
        step();
    endtask

    // ROM={A,B,HALT}: A then B each held HOLD_TICKS ticks, then done.
    task automatic test_halt_program();
        bit ok;
        rom = '{16'hA5A5, 16'h5A5A, HALT, 16'h0BAD};
        build_model(16);
        clear_mon();
        ready_mode = 1; tick_en = 1;
        step();
        pulse_start();
        @(negedge clk);
        checks++; if ({mem_en, mem_addr} !== {1'b1, 2'd0}) begin errors++; $display("FAIL halt_fetch_latency: en/addr got %b/%0d want 1/0", mem_en, mem_addr); end
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL halt_valid_early: got %b want 0", cmd_valid); end
        @(negedge clk);
        checks++; if ({cmd_valid, cmd_data} !== {1'b1, 16'hA5A5}) begin errors++; $display("FAIL halt_issue_latency: valid/data got %b/%h want 1/a5a5", cmd_valid, cmd_data); end
        wait_for(2, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL halt_done_timeout: done never seen, want pulse"); end
        checks++; if ({cmd_data, busy} !== {SAFE, 1'b0}) begin errors++; $display("FAIL halt_done_outputs: data/busy got %h/%b want %h/0", cmd_data, busy, SAFE); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL halt_done_pulse: done/busy got %b/%b want 0/0", done, busy); end
        checks++; if (fetch_q.size() != exp_fetch.size()) begin errors++; $display("FAIL halt_fetch_count: got %0d want %0d", fetch_q.size(), exp_fetch.size()); end
        for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++) begin
            checks++; if (fetch_q[i] != exp_fetch[i]) begin errors++; $display("FAIL halt_fetch_addr[%0d]: got %0d want %0d", i, fetch_q[i], exp_fetch[i]); end
        end
        checks++; if (xfer_q.size() != exp_issue.size()) begin errors++; $display("FAIL halt_xfer_count: got %0d want %0d", xfer_q.size(), exp_issue.size()); end
        for (int i = 0; i < xfer_q.size() && i < exp_issue.size(); i++) begin
            checks++; if (xfer_q[i] !== exp_issue[i]) begin errors++; $display("FAIL halt_xfer_word[%0d]: got %h want %h", i, xfer_q[i], exp_issue[i]); end
        end
        checks++; if (hold_q.size() != 2) begin errors++; $display("FAIL halt_hold_count: got %0d want 2", hold_q.size()); end
        foreach (hold_q[i]) begin
            checks++; if (hold_q[i] != HOLD_TICKS) begin errors++; $display("FAIL halt_hold_ticks[%0d]: got %0d want %0d", i, hold_q[i], HOLD_TICKS); end
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL halt_hold_data: %0d unstable cycles want 0", hold_bad); end
        // start from DONE restarts at address 0.
        step();
        pulse_start();
        @(negedge clk);
        checks++; if ({mem_en, mem_addr, busy} !== {1'b1, 2'd0, 1'b1}) begin errors++; $display("FAIL done_restart: en/addr/busy got %b/%0d/%b want 1/0/1", mem_en, mem_addr, busy); end
        pulse_stop();
    endtask

    // ROM={1234,LOOP}: 1234 repeats, addresses 0,1,0,1..., no done.
    task automatic test_loop();
        bit ok;
        rom = '{16'h1234, LOOP, 16'h0BAD, 16'h0BAD};
        clear_mon();
        ready_mode = 2; tick_en = 1;
        step();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (xfer_q.size() >= 4) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL loop_timeout: %0d transfers want 4", xfer_q.size()); end
        pulse_stop();
        build_model(fetch_q.size());
        checks++; if (fetch_q.size() < 7) begin errors++; $display("FAIL loop_fetch_count: got %0d want >=7", fetch_q.size()); end
        for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++) begin
            checks++; if (fetch_q[i] != exp_fetch[i]) begin errors++; $display("FAIL loop_fetch_addr[%0d]: got %0d want %0d", i, fetch_q[i], exp_fetch[i]); end
        end
        for (int i = 0; i < xfer_q.size() && i < exp_issue.size(); i++) begin
            checks++; if (xfer_q[i] !== exp_issue[i]) begin errors++; $display("FAIL loop_xfer_word[%0d]: got %h want %h", i, xfer_q[i], exp_issue[i]); end
        end
        foreach (hold_q[i]) begin
            checks++; if (hold_q[i] != HOLD_TICKS) begin errors++; $display("FAIL loop_hold_ticks[%0d]: got %0d want %0d", i, hold_q[i], HOLD_TICKS); end
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL loop_done: got %0d pulses want 0", done_cnt); end
    endtask

    // cmd_ready low for 20 cycles in ISSUE with ticks arriving.
    task automatic test_stall();
        bit ok;
        rom = '{16'h5555, 16'h6666, HALT, 16'h0BAD};
        clear_mon();
        ready_mode = 0; tick_en = 1;
        step();
        pulse_start();
        wait_for(0, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_valid_timeout: cmd_valid never seen, want 1"); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({cmd_valid, cmd_data, mem_en, mem_addr, busy} !== {1'b1, 16'h5555, 1'b0, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid/data/en/addr/busy got %b/%h/%b/%0d/%b want 1/5555/0/0/1",
                         i, cmd_valid, cmd_data, mem_en, mem_addr, busy);
            end
        end
        ready_mode = 1;
        wait_for(2, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout: done never seen, want pulse"); end
        checks++; if (xfer_q.size() != 2) begin errors++; $display("FAIL stall_xfer_count: got %0d want 2", xfer_q.size()); end
        checks++; if (hold_q.size() != 2) begin errors++; $display("FAIL stall_hold_count: got %0d want 2", hold_q.size()); end
        foreach (hold_q[i]) begin
            checks++; if (hold_q[i] != HOLD_TICKS) begin errors++; $display("FAIL stall_hold_ticks[%0d]: got %0d want %0d", i, hold_q[i], HOLD_TICKS); end
        end
        pulse_stop();
    endtask

    // stop in HOLD and in ISSUE.
    task automatic test_stop();
        bit ok;
        rom = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        clear_mon();
        ready_mode = 1; tick_en = 1;
        step();
        pulse_start();
        wait_for(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_hold_xfer_timeout: no transfer, want one"); end
        pulse_stop();
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_data, mem_en, mem_addr, busy} !== {1'b0, SAFE, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL stop_in_hold: valid/data/en/addr/busy got %b/%h/%b/%0d/%b want 0/%h/0/0/0",
                     cmd_valid, cmd_data, mem_en, mem_addr, busy, SAFE);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if ({cmd_valid, mem_en, busy} !== 3'b000) begin errors++; $display("FAIL stop_stays_idle[%0d]: valid/en/busy got %b/%b/%b want 0/0/0", i, cmd_valid, mem_en, busy); end
        end
        clear_mon();
        ready_mode = 0;
        step();
        pulse_start();
        wait_for(0, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_issue_valid_timeout: cmd_valid never seen, want 1"); end
        pulse_stop();
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_data, mem_en, mem_addr, busy} !== {1'b0, SAFE, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL stop_in_issue: valid/data/en/addr/busy got %b/%h/%b/%0d/%b want 0/%h/0/0/0",
                     cmd_valid, cmd_data, mem_en, mem_addr, busy, SAFE);
        end
        ready_mode = 1;
        repeat (6) @(negedge clk);
        checks++; if (xfer_q.size() != 0) begin errors++; $display("FAIL stop_dropped_handshake: got %0d transfers want 0", xfer_q.size()); end
    endtask

    // start+stop together from IDLE, and start while busy.
    task automatic test_start_stop();
        bit ok;
        step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({busy, mem_en} !== 2'b00) begin errors++; $display("FAIL start_stop_same_cycle[%0d]: busy/en got %b/%b want 0/0", i, busy, mem_en); end
        end
        rom = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        clear_mon();
        ready_mode = 1; tick_en = 1;
        step();
        pulse_start();
        wait_for(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_xfer_timeout: no transfer, want one"); end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_for(3, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_fetch_timeout: no fetch, want one"); end
        checks++; if (mem_addr !== 2'd1) begin errors++; $display("FAIL busy_start_ignored: next fetch addr got %0d want 1", mem_addr); end
        pulse_stop();
    endtask

    // No markers: addresses wrap 0..3,0..; rst mid-run restores reset values.
    task automatic test_wrap_and_rst();
        bit ok;
        rom = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        clear_mon();
        ready_mode = 2; tick_en = 1;
        step();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fetch_q.size() >= 7) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: %0d fetches want 7", fetch_q.size()); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr, cmd_valid, cmd_data, busy, done} !== {1'b0, 2'd0, 1'b0, SAFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_run: en/addr/valid/data/busy/done got %b/%0d/%b/%h/%b/%b want 0/0/0/%h/0/0",
                     mem_en, mem_addr, cmd_valid, cmd_data, busy, done, SAFE);
        end
        build_model(fetch_q.size());
        for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++) begin
            checks++; if (fetch_q[i] != exp_fetch[i]) begin errors++; $display("FAIL wrap_fetch_addr[%0d]: got %0d want %0d", i, fetch_q[i], exp_fetch[i]); end
        end
        checks++; if (xfer_q.size() + 1 < exp_issue.size()) begin errors++; $display("FAIL wrap_xfer_count: got %0d want >=%0d", xfer_q.size(), exp_issue.size() - 1); end
        for (int i = 0; i < xfer_q.size() && i < exp_issue.size(); i++) begin
            checks++; if (xfer_q[i] !== exp_issue[i]) begin errors++; $display("FAIL wrap_xfer_word[%0d]: got %h want %h", i, xfer_q[i], exp_issue[i]); end
        end
        foreach (hold_q[i]) begin
            checks++; if (hold_q[i] != HOLD_TICKS) begin errors++; $display("FAIL wrap_hold_ticks[%0d]: got %0d want %0d", i, hold_q[i], HOLD_TICKS); end
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL wrap_hold_data: %0d unstable cycles want 0", hold_bad); end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        clear_mon();
        test_reset();
        test_halt_program();
        test_loop();
        test_stall();
        test_stop();
        test_start_stop();
        test_wrap_and_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
